// File: rtl/fifo_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_test_pkg
//  Description : Shared state encoding and timing constants for the FIFO
//                lock-step test sequencer and its per-lane checkers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_test_pkg;

   // Sequencer FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_CHECK  = 3'd4
   } state_e;

   // Cycles spent between the last write and the first read
   localparam int SETTLE_CYC = 2;

   // Cycles from rd_en to the matching read data at the lane FIFOs
   localparam int READ_LAT = 1;

   // Saturation value of the pass counter
   localparam logic [15:0] PASS_CNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/fifo_test_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_test_sequencer_if
//  Description : Bundle between the test sequencer (master) and the K lane
//                FIFOs under test (slave): broadcast write side, per-lane
//                read data and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_test_sequencer_if #(
   parameter int N = 32,
   parameter int K = 192
);
   logic           wr_en_o;
   logic           rd_en_o;
   logic [N-1:0]   din_o;
   logic           inj_sbit_o;
   logic           inj_dbit_o;
   logic [K*N-1:0] dout_i;
   logic [K-1:0]   valid_i;
   logic [K-1:0]   full_i;
   logic [K-1:0]   empty_i;
   logic [K-1:0]   sbiterr_i;
   logic [K-1:0]   dbiterr_i;

   modport master (
      output wr_en_o, rd_en_o, din_o, inj_sbit_o, inj_dbit_o,
      input  dout_i, valid_i, full_i, empty_i, sbiterr_i, dbiterr_i
   );

   modport slave (
      input  wr_en_o, rd_en_o, din_o, inj_sbit_o, inj_dbit_o,
      output dout_i, valid_i, full_i, empty_i, sbiterr_i, dbiterr_i
   );
endinterface
`default_nettype wire

// File: rtl/fifo_lane_check.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_lane_check
//  Description : Per-lane checker. Compares read data against the expected
//                pattern, tracks the expected ECC flag behaviour for injected
//                errors and keeps sticky error / warning flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_lane_check
   import fifo_test_pkg::*;
#(
   parameter int N = 32
) (
   input  wire logic         clk_i,
   input  wire logic         rst_n_i,
   input  wire logic         clear_i,
   input  wire logic         busy_i,
   input  wire logic         exp_vld_i,
   input  wire logic [N-1:0] exp_data_i,
   input  wire logic         is_r0_i,
   input  wire logic         is_r1_i,
   input  wire logic         inj_s_i,
   input  wire logic         inj_d_i,
   input  wire logic         chk_full_i,
   input  wire logic         chk_empty_i,
   input  wire logic [N-1:0] dout_i,
   input  wire logic         valid_i,
   input  wire logic         full_i,
   input  wire logic         empty_i,
   input  wire logic         sbiterr_i,
   input  wire logic         dbiterr_i,
   output logic              err_o,
   output logic              warn_o
);

   logic err_q, err_d;
   logic warn_q, warn_d;
   logic set_err, set_warn;

   // Classify this cycle's lane sample into error / warning set conditions
   always_comb begin
      set_err  = 1'b0;
      set_warn = 1'b0;
      if (chk_full_i && !full_i) begin
         set_err = 1'b1;
      end
      if (chk_empty_i && !empty_i) begin
         set_err = 1'b1;
      end
      if (exp_vld_i) begin
         // A double-bit injected word legitimately returns corrupted data
         if (!valid_i) begin
            set_err = 1'b1;
         end else if ((dout_i != exp_data_i) && !(is_r1_i && inj_d_i)) begin
            set_err = 1'b1;
         end
         if (is_r0_i && inj_s_i) begin
            if (sbiterr_i) set_warn = 1'b1;
            else           set_err  = 1'b1;
         end else if (sbiterr_i) begin
            set_err = 1'b1;
         end
         if (is_r1_i && inj_d_i) begin
            if (dbiterr_i) set_warn = 1'b1;
            else           set_err  = 1'b1;
         end else if (dbiterr_i) begin
            set_err = 1'b1;
         end
      end else if (busy_i && valid_i) begin
         set_err = 1'b1;
      end
      // A set condition takes priority over a simultaneous clear
      err_d  = set_err  | (err_q  & ~clear_i);
      warn_d = set_warn | (warn_q & ~clear_i);
   end

   // Sticky flag registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q  <= 1'b0;
         warn_q <= 1'b0;
      end else begin
         err_q  <= err_d;
         warn_q <= warn_d;
      end
   end

   assign err_o  = err_q;
   assign warn_o = warn_q;

endmodule
`default_nettype wire

// File: rtl/fifo_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_test_sequencer
//  Description : Drives K lane FIFOs in lock-step through fill / settle /
//                drain / check passes with an incrementing data pattern and
//                optional ECC error injection; aggregates per-lane results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_test_sequencer
   import fifo_test_pkg::*;
#(
   parameter int N     = 32,
   parameter int K     = 192,
   parameter int DEPTH = 16
) (
   input  wire logic              clk_i,
   input  wire logic              rst_n_i,
   input  wire logic              start_i,
   input  wire logic              cont_i,
   input  wire logic              clear_i,
   input  wire logic [1:0]        inj_en_i,
   fifo_test_sequencer_if.master  fif,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [15:0]            pass_cnt_o,
   output logic [K-1:0]           fifo_err_o,
   output logic [K-1:0]           pg_warn_o
);

   // One counter serves FILL, SETTLE and DRAIN; DRAIN is the longest phase
   localparam int             CW          = $clog2(DEPTH + READ_LAT + 1);
   localparam logic [CW-1:0]  FILL_LAST   = CW'(DEPTH - 1);
   localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]  DRAIN_LAST  = CW'(DEPTH + READ_LAT - 1);
   localparam logic [CW-1:0]  RD_CNT      = CW'(DEPTH);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         ridx_q, ridx_d;
   logic [N-1:0]          seed_q, seed_d;
   logic [15:0]           pass_cnt_q, pass_cnt_d;
   logic [15:0]           pass_base;
   logic [1:0]            inj_q, inj_d;
   logic [READ_LAT-1:0]   rd_pipe_q, rd_pipe_d;
   logic [1:0]            rst_sync_q;

   logic                  rd_en;
   logic                  exp_vld;
   logic [N-1:0]          exp_data;
   logic                  chk_full;
   logic                  chk_empty;

   // Reset release is re-timed so the FSM never leaves IDLE on a partial release
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i && rst_sync_q[1]) state_d = ST_FILL;
         ST_FILL:   if (cnt_q == FILL_LAST)       state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == SETTLE_LAST)     state_d = ST_DRAIN;
         ST_DRAIN:  if (cnt_q == DRAIN_LAST)      state_d = ST_CHECK;
         ST_CHECK:  state_d = cont_i ? ST_FILL : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: write/read strobes, pattern data and injection markers
   always_comb begin
      fif.wr_en_o    = (state_q == ST_FILL);
      rd_en          = (state_q == ST_DRAIN) && (cnt_q < RD_CNT);
      fif.rd_en_o    = rd_en;
      fif.din_o      = (state_q == ST_FILL) ? (seed_q + N'(cnt_q)) : '0;
      fif.inj_sbit_o = (state_q == ST_FILL) && (cnt_q == CW'(0)) && inj_q[0];
      fif.inj_dbit_o = (state_q == ST_FILL) && (cnt_q == CW'(1)) && inj_q[1];
      busy_o         = (state_q != ST_IDLE);
      done_o         = (state_q == ST_CHECK);
   end

   // Counters, seed, pass count, injection capture and read-valid pipeline
   always_comb begin
      if ((state_q == ST_IDLE) || (state_d != state_q)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      inj_d = ((state_d == ST_FILL) && (state_q != ST_FILL)) ? inj_en_i : inj_q;

      rd_pipe_d[0] = rd_en;
      for (int i = 1; i < READ_LAT; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end

      if (state_q != ST_DRAIN) begin
         ridx_d = '0;
      end else if (exp_vld) begin
         ridx_d = ridx_q + CW'(1);
      end else begin
         ridx_d = ridx_q;
      end

      seed_d = (state_q == ST_CHECK) ? (seed_q + N'(1)) : seed_q;

      pass_base  = clear_i ? 16'd0 : pass_cnt_q;
      pass_cnt_d = pass_base;
      if ((state_q == ST_CHECK) && (pass_base != PASS_CNT_MAX)) begin
         pass_cnt_d = pass_base + 16'd1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q      <= '0;
         ridx_q     <= '0;
         seed_q     <= '0;
         pass_cnt_q <= '0;
         inj_q      <= '0;
         rd_pipe_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         ridx_q     <= ridx_d;
         seed_q     <= seed_d;
         pass_cnt_q <= pass_cnt_d;
         inj_q      <= inj_d;
         rd_pipe_q  <= rd_pipe_d;
      end
   end

   assign exp_vld    = rd_pipe_q[READ_LAT-1];
   assign exp_data   = seed_q + N'(ridx_q);
   assign chk_full   = (state_q == ST_SETTLE) && (cnt_q == SETTLE_LAST);
   assign chk_empty  = (state_q == ST_CHECK);
   assign pass_cnt_o = pass_cnt_q;

   for (genvar g = 0; g < K; g++) begin : g_lane
      fifo_lane_check #(
         .N(N)
      ) u_lane_check (
         .clk_i       (clk_i),
         .rst_n_i     (rst_n_i),
         .clear_i     (clear_i),
         .busy_i      (busy_o),
         .exp_vld_i   (exp_vld),
         .exp_data_i  (exp_data),
         .is_r0_i     (ridx_q == CW'(0)),
         .is_r1_i     (ridx_q == CW'(1)),
         .inj_s_i     (inj_q[0]),
         .inj_d_i     (inj_q[1]),
         .chk_full_i  (chk_full),
         .chk_empty_i (chk_empty),
         .dout_i      (fif.dout_i[g*N +: N]),
         .valid_i     (fif.valid_i[g]),
         .full_i      (fif.full_i[g]),
         .empty_i     (fif.empty_i[g]),
         .sbiterr_i   (fif.sbiterr_i[g]),
         .dbiterr_i   (fif.dbiterr_i[g]),
         .err_o       (fifo_err_o[g]),
         .warn_o      (pg_warn_o[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_test_sequencer
//  Description : Self-checking bench: ideal ECC lane-FIFO model with fault
//                knobs, table-driven passes, hand-written corner sequences
//                and randomized passes checked against a rule-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_test_sequencer;
   localparam int N     = 32;
   localparam int K     = 4;
   localparam int DEPTH = 16;
   localparam int BOUND = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, cont = 1'b0, clear = 1'b0;
   logic [1:0] inj_en = 2'b00;
   logic busy, done;
   logic [15:0] pass_cnt;
   logic [K-1:0] err, warn;

   fifo_test_sequencer_if #(.N(N), .K(K)) fif();

   fifo_test_sequencer #(.N(N), .K(K), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cont_i(cont),
      .clear_i(clear), .inj_en_i(inj_en), .fif(fif), .busy_o(busy),
      .done_o(done), .pass_cnt_o(pass_cnt), .fifo_err_o(err), .pg_warn_o(warn)
   );

   always #5 clk = ~clk;

   // Fault knobs for the FIFO model
   int           corr_lane = -1;
   int           corr_ridx = 0;
   logic [N-1:0] corr_mask = 32'h5;
   bit           force_sb  = 1'b0;
   bit           stuck0    = 1'b0;

   // Ideal ECC FIFO shared by all lanes (writes are broadcast)
   typedef struct { logic [N-1:0] d; bit s; bit db; } word_t;
   word_t fq[$];

   always @(posedge clk or negedge rst_n) begin
      logic [K*N-1:0] dv;
      logic [K-1:0] vv, sv, bv, fv, ev;
      logic [N-1:0] d;
      word_t w;
      int r;
      if (!rst_n) begin
         fq.delete();
         fif.dout_i <= '0; fif.valid_i <= '0; fif.sbiterr_i <= '0;
         fif.dbiterr_i <= '0; fif.full_i <= '0; fif.empty_i <= '1;
      end else begin
         dv = fif.dout_i; vv = '0; sv = '0; bv = '0;
         if (fif.rd_en_o && fq.size() > 0) begin
            r = DEPTH - fq.size();
            w = fq.pop_front();
            for (int l = 0; l < K; l++) begin
               d = w.db ? (w.d ^ 32'h3) : w.d;   // double-bit error escapes ECC
               if (l == corr_lane && r == corr_ridx) d = d ^ corr_mask;
               dv[l*N +: N] = d;
               vv[l] = 1'b1;
               sv[l] = w.s || (force_sb && r == 0);
               bv[l] = w.db;
            end
         end
         if (fif.wr_en_o) fq.push_back('{fif.din_o, fif.inj_sbit_o, fif.inj_dbit_o});
         fv = (fq.size() == DEPTH) ? '1 : '0;
         if (stuck0) fv[0] = 1'b0;
         ev = (fq.size() == 0) ? '1 : '0;
         fif.dout_i <= dv; fif.valid_i <= vv; fif.sbiterr_i <= sv;
         fif.dbiterr_i <= bv; fif.full_i <= fv; fif.empty_i <= ev;
      end
   end

   // Monitor: done pulses and write stream
   int done_cnt = 0;
   logic [N-1:0] wr_log[$];
   int s_log[$];
   int d_log[$];
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (fif.wr_en_o) begin
         if (fif.inj_sbit_o) s_log.push_back(wr_log.size() % DEPTH);
         if (fif.inj_dbit_o) d_log.push_back(wr_log.size() % DEPTH);
         wr_log.push_back(fif.din_o);
      end
   end

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      wr_log.delete(); s_log.delete(); d_log.delete();
   endtask

   task automatic pulse_clear();
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Start a run of npass passes (cont held until the last) and wait for idle
   task automatic run_pass(input int npass, input logic [1:0] inj);
      int t, d0;
      d0 = done_cnt;
      @(negedge clk);
      inj_en = inj; cont = (npass > 1); start = 1'b1;
      @(negedge clk) start = 1'b0;
      t = 0;
      while (busy && t < BOUND * npass) begin
         @(negedge clk);
         t++;
         if (cont && (done_cnt - d0 == npass - 1) && !done) cont = 1'b0;
      end
      cont = 1'b0;
      chk("pass_timeout", 64'(t < BOUND * npass), 64'd1);
      chk("done_pulses", 64'(done_cnt - d0), 64'(npass));
   endtask

   // Write stream must be seed+idx for each consecutive pass
   task automatic chk_din(input int seed0, input int npass);
      bit ok;
      ok = (wr_log.size() == npass * DEPTH);
      for (int i = 0; i < wr_log.size(); i++)
         if (wr_log[i] !== N'(seed0 + i / DEPTH + i % DEPTH)) ok = 1'b0;
      chk("din_seq", 64'(ok), 64'd1);
   endtask

   task automatic chk_inj(input logic [1:0] inj);
      bit ok;
      ok = inj[0] ? (s_log.size() == 1 && s_log[0] == 0) : (s_log.size() == 0);
      if (inj[1]) ok = ok && (d_log.size() == 1 && d_log[0] == 1);
      else        ok = ok && (d_log.size() == 0);
      chk("inj_marks", 64'(ok), 64'd1);
   endtask

   // Rule-level expectation for one pass under the given fault knobs
   function automatic void ref_flags(input logic [1:0] inj, input int cl, input int cr,
                                     input bit fsb, input bit st,
                                     output logic [K-1:0] e_err, output logic [K-1:0] e_warn);
      e_err = '0; e_warn = '0;
      if (st) e_err[0] = 1'b1;
      if (inj != 2'b00) e_warn = '1;
      if (fsb && !inj[0]) e_err = '1;
      if (cl >= 0 && !(cr == 1 && inj[1])) e_err[cl] = 1'b1;
   endfunction

   typedef struct {
      logic [1:0] inj; int cl; int cr; bit fsb; bit st;
      logic [K-1:0] e_err; logic [K-1:0] e_warn;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int exp_seed, t, nrd;
      logic [K-1:0] prev_err, e_err, e_warn;
      logic [1:0] rinj;

      tbl[0] = '{2'b00, -1, 0, 0, 0, 4'b0000, 4'b0000};
      tbl[1] = '{2'b00,  2, 5, 0, 0, 4'b0100, 4'b0000};
      tbl[2] = '{2'b01, -1, 0, 0, 0, 4'b0000, 4'b1111};
      tbl[3] = '{2'b00, -1, 0, 1, 0, 4'b1111, 4'b0000};
      tbl[4] = '{2'b10, -1, 0, 0, 0, 4'b0000, 4'b1111};
      tbl[5] = '{2'b10,  1, 1, 0, 0, 4'b0000, 4'b1111};
      tbl[6] = '{2'b00, -1, 0, 0, 1, 4'b0001, 4'b0000};
      tbl[7] = '{2'b11,  3, 9, 0, 0, 4'b1000, 4'b1111};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
      chk("rst_flags", 64'({err, warn}), 64'd0);
      chk("rst_strobes", 64'({fif.wr_en_o, fif.rd_en_o, done, fif.din_o}), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      exp_seed = 0;

      // Table-driven single passes
      for (int i = 0; i < 8; i++) begin
         corr_lane = tbl[i].cl; corr_ridx = tbl[i].cr; corr_mask = 32'h5;
         force_sb = tbl[i].fsb; stuck0 = tbl[i].st;
         pulse_clear();
         chk("clear_flags", 64'({err, warn}), 64'd0);
         clear_logs();
         run_pass(1, tbl[i].inj);
         chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].e_err));
         chk($sformatf("v%0d_warn", i), 64'(warn), 64'(tbl[i].e_warn));
         chk("pass_cnt_1", 64'(pass_cnt), 64'd1);
         chk_din(exp_seed, 1);
         chk_inj(tbl[i].inj);
         exp_seed++;
      end
      corr_lane = -1; force_sb = 0; stuck0 = 0;

      // full stuck low on lane 0: flag appears exactly on the first DRAIN cycle
      stuck0 = 1'b1;
      pulse_clear();
      clear_logs();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t = 0; prev_err = err;
      while (!fif.rd_en_o && t < BOUND) begin prev_err = err; @(negedge clk); t++; end
      chk("settle_timeout", 64'(t < BOUND), 64'd1);
      chk("full_err_before", 64'(prev_err), 64'd0);
      chk("full_err_after", 64'(err), 64'b0001);
      t = 0;
      while (busy && t < BOUND) begin @(negedge clk); t++; end
      stuck0 = 1'b0;
      pulse_clear();
      chk("full_err_cleared", 64'(err), 64'd0);
      exp_seed++;

      // Asynchronous reset in the middle of DRAIN
      clear_logs();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t = 0; nrd = 0;
      while (nrd < 8 && t < BOUND) begin
         if (fif.rd_en_o) nrd++;
         if (nrd < 8) @(negedge clk);
         t++;
      end
      chk("drain_timeout", 64'(t < BOUND), 64'd1);
      t = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 64'({busy, done, fif.rd_en_o, fif.wr_en_o, fif.din_o}), 64'd0);
      chk("async_rst_cnt", 64'({pass_cnt, err, warn}), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_done_on_abort", 64'(done_cnt - t), 64'd0);
      clear_logs();
      run_pass(1, 2'b00);
      chk_din(0, 1);
      chk("post_rst_flags", 64'({err, warn}), 64'd0);
      chk("post_rst_pass_cnt", 64'(pass_cnt), 64'd1);

      // Three continuous passes from a fresh reset
      do_reset();
      clear_logs();
      run_pass(3, 2'b00);
      chk("cont_pass_cnt", 64'(pass_cnt), 64'd3);
      chk("cont_pass2_din0", 64'((wr_log.size() > 32) ? wr_log[32] : '1), 64'd2);
      chk_din(0, 3);
      chk("cont_flags", 64'({err, warn}), 64'd0);
      exp_seed = 3;

      // Randomized passes against the rule-level model
      for (int i = 0; i < 12; i++) begin
         rinj = 2'($urandom_range(0, 3));
         corr_lane = $urandom_range(0, K);
         if (corr_lane == K) corr_lane = -1;
         corr_ridx = $urandom_range(0, DEPTH - 1);
         corr_mask = $urandom | 32'h1;
         force_sb = ($urandom_range(0, 3) == 0);
         stuck0 = ($urandom_range(0, 3) == 0);
         ref_flags(rinj, corr_lane, corr_ridx, force_sb, stuck0, e_err, e_warn);
         pulse_clear();
         clear_logs();
         run_pass(1, rinj);
         chk($sformatf("rnd%0d_err", i), 64'(err), 64'(e_err));
         chk($sformatf("rnd%0d_warn", i), 64'(warn), 64'(e_warn));
         chk_din(exp_seed, 1);
         exp_seed++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
